// File: rtl/req_mem_ws.sv
// req_mem_ws: request/ready memory slave with byte strobes, wait states and range error
module req_mem_ws #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_i,
  input  logic                req_rnw_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  output logic                req_ready_o,
  output logic [DATA_W-1:0]   req_rdata_o,
  output logic                req_err_o
);
  localparam int NB = DATA_W / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t st;
  logic rnw_q;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] wd_q;
  logic [NB-1:0] be_q;
  logic [3:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic in_rng, go;
  logic [IW-1:0] idx;
  assign in_rng = {1'b0, a_q} < LIM;
  assign idx = a_q[IW-1:0];
  assign go = st == S_WAIT && cnt == 4'd0;
  // Capture in IDLE, count down the wait, then register the one-cycle response
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st <= S_IDLE;
      cnt <= 4'd0;
      req_ready_o <= 1'b0;
      req_err_o <= 1'b0;
      req_rdata_o <= '0;
    end else begin
      req_ready_o <= 1'b0;
      req_err_o <= 1'b0;
      req_rdata_o <= '0;
      case (st)
        S_IDLE: if (req_i) begin
          rnw_q <= req_rnw_i;
          a_q <= req_addr_i;
          wd_q <= req_wdata_i;
          be_q <= req_be_i;
          cnt <= req_rnw_i ? 4'(RD_WAIT) : 4'(WR_WAIT);
          st <= S_WAIT;
        end
        S_WAIT: if (go) begin
          st <= S_RESP;
          req_ready_o <= 1'b1;
          req_err_o <= !in_rng;
          req_rdata_o <= rnw_q && in_rng ? mem[idx] : '0;
        end else cnt <= cnt - 4'd1;
        default: st <= S_IDLE;
      endcase
    end
  end
  // Commit enabled byte lanes of an in-range write on the edge entering RESP
  always_ff @(posedge clk) begin
    if (reset_n && go && !rnw_q && in_rng)
      for (int k = 0; k < NB; k++)
        if (be_q[k]) mem[idx][8*k +: 8] <= wd_q[8*k +: 8];
  end
endmodule

// File: tb/tb_req_mem_ws.sv
// tb_req_mem_ws: directed checks of three req_mem_ws configurations
module tb_req_mem_ws;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req [3];
  logic rnw [3];
  logic [9:0] addr [3];
  logic [31:0] wd [3];
  logic [3:0] be [3];
  logic rdy [3];
  logic err [3];
  logic [31:0] rd [3];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  req_mem_ws u0 (
    .clk(clk), .reset_n(reset_n), .req_i(req[0]), .req_rnw_i(rnw[0]), .req_addr_i(addr[0]),
    .req_wdata_i(wd[0]), .req_be_i(be[0]), .req_ready_o(rdy[0]), .req_rdata_o(rd[0]), .req_err_o(err[0]));
  req_mem_ws #(.DEPTH(1000), .RD_WAIT(3), .WR_WAIT(2)) u1 (
    .clk(clk), .reset_n(reset_n), .req_i(req[1]), .req_rnw_i(rnw[1]), .req_addr_i(addr[1]),
    .req_wdata_i(wd[1]), .req_be_i(be[1]), .req_ready_o(rdy[1]), .req_rdata_o(rd[1]), .req_err_o(err[1]));
  req_mem_ws #(.RD_WAIT(0)) u2 (
    .clk(clk), .reset_n(reset_n), .req_i(req[2]), .req_rnw_i(rnw[2]), .req_addr_i(addr[2]),
    .req_wdata_i(wd[2]), .req_be_i(be[2]), .req_ready_o(rdy[2]), .req_rdata_o(rd[2]), .req_err_o(err[2]));

  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  // One transaction on DUT d; the call starts and ends in an IDLE cycle
  task automatic xact(input int d, input logic r, input logic [9:0] a, input logic [31:0] w,
                      input logic [3:0] b, input int lat, input logic [31:0] erd, input logic eerr,
                      input string t);
    int n;
    req[d] = 1'b1; rnw[d] = r; addr[d] = a; wd[d] = w; be[d] = b;
    @(posedge clk); #1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rdy[d] && n < 30);
    req[d] = 1'b0;
    chk({t, "_lat"}, n, lat);
    chk({t, "_rdata"}, rd[d], erd);
    chk({t, "_err"}, {31'b0, err[d]}, {31'b0, eerr});
    @(posedge clk); #1;
    chk({t, "_pulse"}, {31'b0, rdy[d]}, 32'd0);
  endtask

  initial begin
    logic [9:0] sa [10];
    logic [31:0] sd [10];
    int n, seen;
    int tp [3];
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; rnw[i] = 1'b0; addr[i] = '0; wd[i] = '0; be[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", {31'b0, rdy[i]}, 32'd0);
      chk("rst_err", {31'b0, err[i]}, 32'd0);
      chk("rst_rdata", rd[i], 32'd0);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      sa[i] = 10'(i * 100 + $urandom_range(0, 99));
      sd[i] = $urandom;
      xact(0, 1'b0, sa[i], sd[i], 4'hF, 1, 32'd0, 1'b0, "sweep_wr");
    end
    for (int i = 0; i < 10; i++) xact(0, 1'b1, sa[i], 32'd0, 4'h0, 2, sd[i], 1'b0, "sweep_rd");

    xact(0, 1'b0, 10'd5, 32'hAABBCCDD, 4'hF, 1, 32'd0, 1'b0, "be_full");
    xact(0, 1'b0, 10'd5, 32'h11223344, 4'b0101, 1, 32'd0, 1'b0, "be_part");
    xact(0, 1'b1, 10'd5, 32'd0, 4'h0, 2, 32'hAA22CC44, 1'b0, "be_rd");
    xact(0, 1'b0, 10'd5, 32'hFFFFFFFF, 4'h0, 1, 32'd0, 1'b0, "be_none");
    xact(0, 1'b1, 10'd5, 32'd0, 4'hF, 2, 32'hAA22CC44, 1'b0, "be_none_rd");

    xact(1, 1'b0, 10'd3, 32'hCAFEF00D, 4'hF, 3, 32'd0, 1'b0, "ws_wr");
    xact(1, 1'b1, 10'd3, 32'd0, 4'h0, 4, 32'hCAFEF00D, 1'b0, "ws_rd");

    xact(1, 1'b0, 10'd999, 32'h99990999, 4'hF, 3, 32'd0, 1'b0, "oor_wr999");
    xact(1, 1'b0, 10'd1010, 32'hDEADBEEF, 4'hF, 3, 32'd0, 1'b1, "oor_wr");
    xact(1, 1'b1, 10'd1010, 32'd0, 4'h0, 4, 32'd0, 1'b1, "oor_rd");
    xact(1, 1'b1, 10'd999, 32'd0, 4'h0, 4, 32'h99990999, 1'b0, "oor_rd999");

    req[1] = 1'b1; rnw[1] = 1'b0; addr[1] = 10'd30; wd[1] = 32'h0BADCAFE; be[1] = 4'hF;
    @(posedge clk); #1;
    rnw[1] = 1'b1; addr[1] = 10'd40; wd[1] = 32'hFFFFFFFF; be[1] = 4'h0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rdy[1] && n < 30);
    req[1] = 1'b0;
    chk("churn_lat", n, 3);
    chk("churn_rdata", rd[1], 32'd0);
    @(posedge clk); #1;
    xact(1, 1'b1, 10'd30, 32'd0, 4'h0, 4, 32'h0BADCAFE, 1'b0, "churn_rd");

    xact(1, 1'b0, 10'd7, 32'd0, 4'hF, 3, 32'd0, 1'b0, "rst_wr0");
    req[1] = 1'b1; rnw[1] = 1'b0; addr[1] = 10'd7; wd[1] = 32'h12345678; be[1] = 4'hF;
    @(posedge clk); #1;
    reset_n = 1'b0;
    req[1] = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; seen = seen | int'(rdy[1]); end
    chk("rst_abort_ready", seen, 0);
    xact(1, 1'b1, 10'd7, 32'd0, 4'h0, 4, 32'd0, 1'b0, "rst_rd7");

    xact(2, 1'b0, 10'd100, 32'h00000111, 4'hF, 1, 32'd0, 1'b0, "b2b_wr0");
    xact(2, 1'b0, 10'd200, 32'h00000222, 4'hF, 1, 32'd0, 1'b0, "b2b_wr1");
    xact(2, 1'b0, 10'd300, 32'h00000333, 4'hF, 1, 32'd0, 1'b0, "b2b_wr2");
    req[2] = 1'b1; rnw[2] = 1'b1; addr[2] = 10'd100;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!rdy[2] && n < 30);
      tp[i] = cyc;
      chk("b2b_rdata", rd[2], 32'h111 * (i + 1));
      addr[2] = 10'(100 * (i + 2));
    end
    req[2] = 1'b0;
    chk("b2b_gap01", tp[1] - tp[0], 3);
    chk("b2b_gap12", tp[2] - tp[1], 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
